// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-slave state type
// for the system AHB interconnect.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      DS_IDLE,
      DS_ERR1,
      DS_ERR2
   } ds_state_e;

endpackage

// File: rtl/ahb_addr_decoder.sv
// Parallel base/mask address decoder; lowest index wins
// on overlapping regions.
module ahb_addr_decoder
   import ahb_pkg::*;
#(
   parameter int                           NUM_SLAVES = 4,
   parameter int                           ADDR_W     = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = '0,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = '0
) (
   input  logic [ADDR_W-1:0]     addr,
   output logic [NUM_SLAVES-1:0] hit,
   output logic                  nohit
);

   logic [NUM_SLAVES-1:0] raw;
   logic                  found;

   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         raw[i] = (addr & SLV_MASK[i*ADDR_W +: ADDR_W])
                  == SLV_BASE[i*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      hit   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (raw[i] && !found) begin
            hit[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign nohit = ~|raw;

endmodule

// File: rtl/ahb_slave_interconnect.sv
// AHB-Lite decoder, slave mux and default error slave.
// Optional stall watchdog: define AHB_MUX_TIMEOUT_EN.
module ahb_slave_interconnect
   import ahb_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {
      32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {
      32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [ADDR_W-1:0]            HADDR,
   input  logic [1:0]                   HTRANS,
   output logic [NUM_SLAVES-1:0]        HSEL,
   input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
   input  logic [2*NUM_SLAVES-1:0]      HRESP_S,
   input  logic [DATA_W*NUM_SLAVES-1:0] HRDATA_S,
   output logic                         HREADY,
   output logic [1:0]                   HRESP,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         TIMEOUT_IRQ
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num
      $error("NUM_SLAVES must be 1..16");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_to
      $error("TIMEOUT_CYCLES must be >= 2");
   end

   logic [NUM_SLAVES-1:0] hit;
   logic                  nohit;
   logic                  req;
   logic [NUM_SLAVES:0]   dsel, dsel_nxt;
   ds_state_e             ds_q, ds_d;
   logic                  slv_sel;
   logic                  slv_rdy;
   logic [1:0]            slv_resp;
   logic [DATA_W-1:0]     rdata;

   ahb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_W     (ADDR_W),
      .SLV_BASE   (SLV_BASE),
      .SLV_MASK   (SLV_MASK)
   ) u_dec (
      .addr  (HADDR),
      .hit   (hit),
      .nohit (nohit)
   );

   assign req  = (HTRANS == HTRANS_NONSEQ) ||
                 (HTRANS == HTRANS_SEQ);
   assign HSEL = hit & {NUM_SLAVES{req}};

   // IDLE/BUSY leaves no data phase, so unmapped idles finish OKAY
   always_comb begin
      dsel_nxt = '0;
      if (req && nohit) begin
         dsel_nxt[NUM_SLAVES] = 1'b1;
      end else if (req) begin
         dsel_nxt[NUM_SLAVES-1:0] = hit;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dsel <= '0;
      end else if (HREADY) begin
         dsel <= dsel_nxt;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         ds_q <= DS_IDLE;
      end else begin
         ds_q <= ds_d;
      end
   end

   always_comb begin
      ds_d = ds_q;
      unique case (ds_q)
         DS_IDLE: if (HREADY && req && nohit) ds_d = DS_ERR1;
         DS_ERR1: ds_d = DS_ERR2;
         DS_ERR2: ds_d = (req && nohit) ? DS_ERR1 : DS_IDLE;
         default: ds_d = DS_IDLE;
      endcase
   end

   assign slv_sel = |dsel[NUM_SLAVES-1:0];

   always_comb begin
      slv_rdy  = 1'b1;
      slv_resp = HRESP_OKAY;
      rdata    = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (dsel[i]) begin
            slv_rdy  = HREADYOUT_S[i];
            slv_resp = HRESP_S[2*i +: 2];
         end
         rdata = rdata |
                 (HRDATA_S[i*DATA_W +: DATA_W] & {DATA_W{dsel[i]}});
      end
   end

`ifdef AHB_MUX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             to_fire;
   logic             to_err2_q;
   logic             to_irq_q;

   assign to_fire = slv_sel && !to_err2_q &&
                    (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         to_cnt    <= '0;
         to_err2_q <= 1'b0;
         to_irq_q  <= 1'b0;
      end else begin
         if (HREADY) begin
            to_cnt <= '0;
         end else if (slv_sel && !slv_rdy) begin
            to_cnt <= to_cnt + 1'b1;
         end
         to_err2_q <= to_fire;
         if (to_fire) begin
            to_irq_q <= 1'b1;
         end
      end
   end

   assign TIMEOUT_IRQ = to_irq_q;
`else
   assign TIMEOUT_IRQ = 1'b0;
`endif

   always_comb begin
      HREADY = slv_rdy;
      HRESP  = slv_resp;
      HRDATA = rdata;
      if (dsel[NUM_SLAVES]) begin
         HREADY = (ds_q == DS_ERR2);
         HRESP  = HRESP_ERROR;
      end
`ifdef AHB_MUX_TIMEOUT_EN
      // watchdog overrides a hung slave with its own ERROR pair
      if (to_fire) begin
         HREADY = 1'b0;
         HRESP  = HRESP_ERROR;
      end else if (to_err2_q) begin
         HREADY = 1'b1;
         HRESP  = HRESP_ERROR;
      end
`endif
   end

endmodule

// File: tb/tb_ahb_slave_interconnect.sv
// Randomised and directed bench for ahb_slave_interconnect
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ahb_slave_interconnect;

   localparam int NS = 2;
   localparam int TO = 8;
   localparam logic [NS*32-1:0] BASE = {32'h4000_0000, 32'h2000_0000};
   localparam logic [NS*32-1:0] MASK = {32'hFFFF_F000, 32'hFFFC_0000};

   logic           clk = 1'b0;
   logic           rstn;
   logic [31:0]    haddr;
   logic [1:0]     htrans;
   logic [NS-1:0]  hsel;
   logic [NS-1:0]  hrdyo;
   logic [2*NS-1:0] hresp_s;
   logic [32*NS-1:0] hrdata_s;
   logic           hready;
   logic [1:0]     hresp;
   logic [31:0]    hrdata;
   logic           irq;

   always #5 clk = ~clk;

   ahb_slave_interconnect #(
      .NUM_SLAVES     (NS),
      .ADDR_W         (32),
      .DATA_W         (32),
      .SLV_BASE       (BASE),
      .SLV_MASK       (MASK),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .HCLK        (clk),
      .HRESETn     (rstn),
      .HADDR       (haddr),
      .HTRANS      (htrans),
      .HSEL        (hsel),
      .HREADYOUT_S (hrdyo),
      .HRESP_S     (hresp_s),
      .HRDATA_S    (hrdata_s),
      .HREADY      (hready),
      .HRESP       (hresp),
      .HRDATA      (hrdata),
      .TIMEOUT_IRQ (irq)
   );

   int total = 0;
   int bad   = 0;

   // model: which data phase is running and for how many cycles
   typedef enum int {K_NONE, K_SLV, K_DS} kind_e;
   kind_e       m_kind = K_NONE;
   int          m_slv  = 0;
   int          m_dcyc = 0;
   bit          m_irq  = 1'b0;
   logic        e_rdy;
   logic [1:0]  e_resp;
   logic [31:0] e_data;

   function automatic int decode(input logic [31:0] a);
      if ((a & 32'hFFFC_0000) == 32'h2000_0000) return 0;
      if ((a & 32'hFFFF_F000) == 32'h4000_0000) return 1;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_check();
      logic [NS-1:0] hs_exp;
      int d;
      e_rdy  = 1'b1;
      e_resp = 2'b00;
      e_data = '0;
      case (m_kind)
         K_DS: begin
            e_rdy  = (m_dcyc == 1);
            e_resp = 2'b01;
         end
         K_SLV: begin
            e_data = hrdata_s[m_slv*32 +: 32];
            e_rdy  = hrdyo[m_slv];
            e_resp = hresp_s[m_slv*2 +: 2];
`ifdef AHB_MUX_TIMEOUT_EN
            if (m_dcyc == TO - 1) begin
               e_rdy  = 1'b0;
               e_resp = 2'b01;
            end else if (m_dcyc == TO) begin
               e_rdy  = 1'b1;
               e_resp = 2'b01;
            end
`endif
         end
         default: ;
      endcase
      d = decode(haddr);
      hs_exp = '0;
      if (htrans[1] && d >= 0) hs_exp[d] = 1'b1;
      chk("hready", {31'b0, hready}, {31'b0, e_rdy});
      chk("hresp", {30'b0, hresp}, {30'b0, e_resp});
      chk("hrdata", hrdata, e_data);
      chk("hsel", {30'b0, hsel}, {30'b0, hs_exp});
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic model_update();
      int d;
      if (!rstn) begin
         m_kind = K_NONE;
         m_dcyc = 0;
         m_irq  = 1'b0;
         return;
      end
`ifdef AHB_MUX_TIMEOUT_EN
      if (m_kind == K_SLV && m_dcyc == TO - 1) m_irq = 1'b1;
`endif
      if (e_rdy) begin
         d = decode(haddr);
         m_dcyc = 0;
         if (!htrans[1]) begin
            m_kind = K_NONE;
         end else if (d < 0) begin
            m_kind = K_DS;
         end else begin
            m_kind = K_SLV;
            m_slv  = d;
         end
      end else begin
         m_dcyc++;
      end
   endtask

   task automatic half();
      @(negedge clk);
      model_check();
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cyc();
      half();
      adv();
   endtask

   task automatic drv(input logic [31:0] a, input logic [1:0] t,
                      input logic [1:0] rdy, input logic [31:0] d0,
                      input logic [31:0] d1);
      haddr    = a;
      htrans   = t;
      hrdyo    = rdy;
      hresp_s  = '0;
      hrdata_s = {d1, d0};
   endtask

   initial begin
      logic [31:0] a;
      rstn = 1'b0;
      drv(32'h0, 2'b00, 2'b11, 32'h0, 32'h0);
      repeat (2) begin
         @(posedge clk);
         model_update();
      end
      #1;
      rstn = 1'b1;

      // reset state
      half();
      chk("lit_rst_hready", {31'b0, hready}, 32'd1);
      chk("lit_rst_hresp", {30'b0, hresp}, 32'd0);
      chk("lit_rst_hrdata", hrdata, 32'd0);
      chk("lit_rst_hsel", {30'b0, hsel}, 32'd0);
      adv();

      // single read, one wait state
      drv(32'h2000_0010, 2'b10, 2'b11, 32'h0, 32'h0);
      half();
      chk("lit_rd_hsel", {30'b0, hsel}, 32'd1);
      adv();
      drv(32'h0, 2'b00, 2'b10, 32'hCAFE_F00D, 32'h1111_1111);
      half();
      chk("lit_rd_wait", {31'b0, hready}, 32'd0);
      adv();
      drv(32'h0, 2'b00, 2'b11, 32'hCAFE_F00D, 32'h1111_1111);
      half();
      chk("lit_rd_rdy", {31'b0, hready}, 32'd1);
      chk("lit_rd_data", hrdata, 32'hCAFE_F00D);
      adv();

      // unmapped access
      drv(32'h8000_0000, 2'b10, 2'b11, 32'h0, 32'h0);
      half();
      chk("lit_um_hsel", {30'b0, hsel}, 32'd0);
      adv();
      drv(32'h0, 2'b00, 2'b11, 32'h0, 32'h0);
      half();
      chk("lit_um_err1_rdy", {31'b0, hready}, 32'd0);
      chk("lit_um_err1_resp", {30'b0, hresp}, 32'd1);
      adv();
      half();
      chk("lit_um_err2_rdy", {31'b0, hready}, 32'd1);
      chk("lit_um_err2_resp", {30'b0, hresp}, 32'd1);
      adv();
      half();
      chk("lit_um_okay", {30'b0, hresp}, 32'd0);
      adv();

      // back-to-back with slave1 stalling three cycles
      drv(32'h4000_0004, 2'b10, 2'b11, 32'h0, 32'h0);
      half();
      chk("lit_b2b_hsel1", {30'b0, hsel}, 32'd2);
      adv();
      repeat (3) begin
         drv(32'h2000_0000, 2'b10, 2'b01, 32'hAAAA_0000, 32'hBBBB_1111);
         half();
         chk("lit_b2b_stall", {31'b0, hready}, 32'd0);
         chk("lit_b2b_hsel0", {30'b0, hsel}, 32'd1);
         adv();
      end
      drv(32'h2000_0000, 2'b10, 2'b11, 32'hAAAA_0000, 32'hBBBB_1111);
      half();
      chk("lit_b2b_s1data", hrdata, 32'hBBBB_1111);
      adv();
      drv(32'h0, 2'b00, 2'b11, 32'hAAAA_0000, 32'hBBBB_1111);
      half();
      chk("lit_b2b_s0data", hrdata, 32'hAAAA_0000);
      adv();

      // two unmapped in a row
      drv(32'h8000_0000, 2'b10, 2'b11, 32'h0, 32'h0);
      cyc();
      drv(32'h9000_0000, 2'b10, 2'b11, 32'h0, 32'h0);
      half();
      chk("lit_uu_e1", {31'b0, hready}, 32'd0);
      adv();
      half();
      chk("lit_uu_e2", {31'b0, hready}, 32'd1);
      chk("lit_uu_e2_resp", {30'b0, hresp}, 32'd1);
      adv();
      drv(32'h0, 2'b00, 2'b11, 32'h0, 32'h0);
      half();
      chk("lit_uu_e1b", {31'b0, hready}, 32'd0);
      adv();
      half();
      chk("lit_uu_e2b", {31'b0, hready}, 32'd1);
      adv();
      half();
      chk("lit_uu_okay", {30'b0, hresp}, 32'd0);
      adv();

      // IDLE to an unmapped address
      drv(32'h8000_0000, 2'b00, 2'b11, 32'h0, 32'h0);
      cyc();
      drv(32'h0, 2'b00, 2'b11, 32'h0, 32'h0);
      half();
      chk("lit_idle_rdy", {31'b0, hready}, 32'd1);
      chk("lit_idle_resp", {30'b0, hresp}, 32'd0);
      adv();

      // reset in the middle of an error response
      drv(32'h8000_0000, 2'b10, 2'b11, 32'h0, 32'h0);
      cyc();
      drv(32'h0, 2'b00, 2'b11, 32'h0, 32'h0);
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      half();
      chk("lit_mrst_rdy", {31'b0, hready}, 32'd1);
      chk("lit_mrst_resp", {30'b0, hresp}, 32'd0);
      adv();

      // slave0 hangs
      drv(32'h2000_0000, 2'b10, 2'b11, 32'h0, 32'h0);
      cyc();
      drv(32'h0, 2'b00, 2'b10, 32'h5, 32'h0);
`ifdef AHB_MUX_TIMEOUT_EN
      repeat (TO - 1) cyc();
      half();
      chk("lit_to_e1_rdy", {31'b0, hready}, 32'd0);
      chk("lit_to_e1_resp", {30'b0, hresp}, 32'd1);
      adv();
      half();
      chk("lit_to_e2_rdy", {31'b0, hready}, 32'd1);
      chk("lit_to_e2_resp", {30'b0, hresp}, 32'd1);
      chk("lit_to_irq", {31'b0, irq}, 32'd1);
      adv();
      half();
      chk("lit_to_irq_held", {31'b0, irq}, 32'd1);
      adv();
`else
      repeat (20) cyc();
      half();
      chk("lit_hang_rdy", {31'b0, hready}, 32'd0);
      chk("lit_hang_irq", {31'b0, irq}, 32'd0);
      adv();
      drv(32'h0, 2'b00, 2'b11, 32'h5, 32'h0);
      cyc();
`endif

      // randomised traffic
      for (int n = 0; n < 3000; n++) begin
         rstn = ($urandom_range(0, 59) != 0);
         case ($urandom_range(0, 3))
            0: a = 32'h2000_0000 | ($urandom & 32'h0003_FFFF);
            1: a = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
            2: a = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
            default: a = $urandom;
         endcase
         haddr    = a;
         htrans   = 2'($urandom_range(0, 3));
         hrdyo[0] = ($urandom_range(0, 2) != 0);
         hrdyo[1] = ($urandom_range(0, 2) != 0);
         hresp_s  = 4'($urandom);
         hrdata_s = {$urandom, $urandom};
         cyc();
      end
      rstn = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
